// File: rtl/fifo_stream_ctrl_if.sv
`default_nettype none
// ============================================================================
// fifo_stream_ctrl_if : producer, consumer and FIFO-primitive signal bundle
// Rev 1.0
// ============================================================================
interface fifo_stream_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512
) ();
  logic [DATA_W-1:0]      p0_data;
  logic                   p0_valid;
  logic                   p0_ready;
  logic [DATA_W-1:0]      p1_data;
  logic                   p1_valid;
  logic                   p1_ready;
  logic [DATA_W-1:0]      m_data;
  logic                   m_valid;
  logic                   m_ready;
  logic                   fifo_rst;
  logic [DATA_W-1:0]      fifo_di;
  logic                   fifo_wen;
  logic [DATA_W-1:0]      fifo_dout;
  logic                   fifo_ren;
  logic [$clog2(DEPTH):0] level;

  modport slave (
    input  p0_data, p0_valid, p1_data, p1_valid, m_ready, fifo_dout,
    output p0_ready, p1_ready, m_data, m_valid,
    output fifo_rst, fifo_di, fifo_wen, fifo_ren, level
  );

  modport master (
    output p0_data, p0_valid, p1_data, p1_valid, m_ready, fifo_dout,
    input  p0_ready, p1_ready, m_data, m_valid,
    input  fifo_rst, fifo_di, fifo_wen, fifo_ren, level
  );
endinterface
`default_nettype wire

// File: rtl/fifo_stream_ctrl.sv
`default_nettype none
// ============================================================================
// fifo_stream_ctrl : init sequencer, 2:1 round-robin writer, occupancy tracker
//                    and skid-buffered read stream for a block-RAM FIFO
// Rev 1.0
// ============================================================================
module fifo_stream_ctrl #(
  parameter int DATA_W        = 32,
  parameter int DEPTH         = 512,
  parameter int READ_LAT      = 2,
  parameter int RST_CYCLES    = 5,
  parameter int SETTLE_CYCLES = 4
) (
  input  wire logic         clk,
  input  wire logic         rst,
  fifo_stream_ctrl_if.slave bus
);
  localparam int SKID = READ_LAT + 1;
  localparam int CW   = $clog2(SKID + 1);
  localparam int LW   = $clog2(DEPTH) + 1;
  localparam int TMAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {
    INIT_RST  = 2'd0,
    INIT_WAIT = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t               state_q;
  logic [TW-1:0]        tmr_q;
  logic                 fifo_rst_q;
  logic                 run_q;
  logic [LW-1:0]        level_q;
  logic                 rr_q;
  logic [READ_LAT-1:0]  pipe_q;
  logic [DATA_W-1:0]    skid_q [SKID];
  logic [DATA_W-1:0]    skid_d [SKID];
  logic [CW-1:0]        skid_cnt_q, skid_cnt_d;

  logic                 can_wr, grant0, grant1, acc0, acc1, wen, ren, push, pop;
  logic                 ready0, ready1;
  logic [DATA_W-1:0]    di;
  logic [CW-1:0]        inflight;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= INIT_RST;
      tmr_q      <= '0;
      fifo_rst_q <= 1'b1;
      run_q      <= 1'b0;
    end else begin
      case (state_q)
        INIT_RST: begin
          if (tmr_q == TW'(RST_CYCLES - 1)) begin
            state_q    <= INIT_WAIT;
            tmr_q      <= '0;
            fifo_rst_q <= 1'b0;
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end
        INIT_WAIT: begin
          if (tmr_q == TW'(SETTLE_CYCLES - 1)) begin
            state_q <= RUN;
            tmr_q   <= '0;
            run_q   <= 1'b1;
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end
        default: begin
          state_q <= RUN;
          run_q   <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    can_wr = (level_q < LW'(DEPTH));
    // rr_q=0 favours p0 on contention, rr_q=1 favours p1
    grant0 = bus.p0_valid & (~bus.p1_valid | ~rr_q);
    grant1 = bus.p1_valid & (~bus.p0_valid | rr_q);
    ready0 = run_q & grant0 & can_wr;
    ready1 = run_q & grant1 & can_wr;
    acc0   = ready0 & bus.p0_valid;
    acc1   = ready1 & bus.p1_valid;
    wen    = acc0 | acc1;
    di     = acc0 ? bus.p0_data : (acc1 ? bus.p1_data : '0);

    inflight = '0;
    for (int i = 0; i < READ_LAT; i++) inflight = inflight + CW'(pipe_q[i]);
    // credit covers skid occupancy plus reads whose data has not returned yet
    ren  = run_q & (level_q != '0) &
           (({1'b0, skid_cnt_q} + {1'b0, inflight}) < (CW+1)'(SKID));
    push = pipe_q[READ_LAT-1];
    pop  = (skid_cnt_q != '0) & bus.m_ready;
  end

  always_comb begin
    skid_d     = skid_q;
    skid_cnt_d = skid_cnt_q;
    if (pop) begin
      for (int i = 0; i < SKID - 1; i++) skid_d[i] = skid_q[i+1];
      skid_d[SKID-1] = '0;
      skid_cnt_d     = skid_cnt_q - CW'(1);
    end
    if (push) begin
      for (int i = 0; i < SKID; i++)
        if (CW'(i) == skid_cnt_d) skid_d[i] = bus.fifo_dout;
      skid_cnt_d = skid_cnt_d + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      level_q    <= '0;
      rr_q       <= 1'b0;
      pipe_q     <= '0;
      skid_cnt_q <= '0;
      for (int i = 0; i < SKID; i++) skid_q[i] <= '0;
    end else begin
      level_q    <= level_q + LW'(wen) - LW'(ren);
      pipe_q     <= (pipe_q << 1) | READ_LAT'(ren);
      skid_cnt_q <= skid_cnt_d;
      for (int i = 0; i < SKID; i++) skid_q[i] <= skid_d[i];
      if (acc0)      rr_q <= 1'b1;
      else if (acc1) rr_q <= 1'b0;
    end
  end

  assign bus.p0_ready = ready0;
  assign bus.p1_ready = ready1;
  assign bus.m_data   = skid_q[0];
  assign bus.m_valid  = (skid_cnt_q != '0);
  assign bus.fifo_rst = fifo_rst_q;
  assign bus.fifo_di  = di;
  assign bus.fifo_wen = wen;
  assign bus.fifo_ren = ren;
  assign bus.level    = level_q;

endmodule
`default_nettype wire
